// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the CPU-side request/response signals and the byte-wide
//   data-memory bus of the load/store unit.
//   Modports:
//     slave  - the load/store unit itself. It takes the request fields and
//              mem_rd, and drives stall/done/rdata and mem_we/mem_addr/mem_wd.
//     master - the environment, meaning the CPU pipeline plus the data memory.
//              It is the mirror image of slave.
//   Signals:
//     req_valid, req_we, funct3, addr, wdata : request from the CPU
//     stall, done, rdata                     : response to the CPU
//     mem_we, mem_addr, mem_wd               : byte write/address to memory
//     mem_rd                                 : combinational read byte
interface load_store_unit_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int XLEN          = 32
);
   logic                     req_valid;
   logic                     req_we;
   logic [2:0]               funct3;
   logic [XLEN-1:0]          addr;
   logic [XLEN-1:0]          wdata;
   logic                     stall;
   logic                     done;
   logic [XLEN-1:0]          rdata;
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [7:0]               mem_wd;
   logic [7:0]               mem_rd;

   modport slave (
      input  req_valid, req_we, funct3, addr, wdata, mem_rd,
      output stall, done, rdata, mem_we, mem_addr, mem_wd
   );

   modport master (
      output req_valid, req_we, funct3, addr, wdata, mem_rd,
      input  stall, done, rdata, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequences RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) onto a
//   byte-wide data memory, moving one byte per cycle in little-endian order.
//   The CPU stays stalled until the access is complete.
//   Timing of one access:
//     - accept cycle   : IDLE with req_valid set
//     - N byte cycles  : ACCESS, where N is 1, 2 or 4
//     - done cycle     : DONE
//   A load result is sign- or zero-extended. It is shown combinationally
//   during the done cycle and then held in a register.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset; every output reads 0 while it is high
//     bus  - load_store_unit_if.slave (CPU request/response and memory bus)
module load_store_unit #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int XLEN          = 32
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.slave  bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]               state_q,  state_d;
   logic [1:0]               idx_q,    idx_d;
   logic [ADDRESS_WIDTH-1:0] base_q,   base_d;
   logic [XLEN-1:0]          wdata_q,  wdata_d;
   logic [2:0]               funct3_q, funct3_d;
   logic                     we_q,     we_d;
   logic [XLEN-1:0]          buf_q,    buf_d;
   logic [XLEN-1:0]          rdata_q,  rdata_d;

   logic [1:0]               last_idx;
   logic [XLEN-1:0]          load_ext;
   logic                     stall_c;
   logic                     done_c;
   logic                     mem_we_c;
   logic [ADDRESS_WIDTH-1:0] mem_addr_c;
   logic [7:0]               mem_wd_c;

   // Index of the final byte. Size 1x is a word, so funct3=011 counts as a word too.
   always_comb begin
      last_idx = 2'd0;
      if (funct3_q[1]) begin
         last_idx = 2'd3;
      end else if (funct3_q[0]) begin
         last_idx = 2'd1;
      end
   end

   // Extend the assembled load. funct3[2] selects zero extension.
   always_comb begin
      load_ext = buf_q;
      case (funct3_q[1:0])
         2'b00: load_ext = funct3_q[2] ? {{(XLEN-8){1'b0}}, buf_q[7:0]}
                                       : {{(XLEN-8){buf_q[7]}}, buf_q[7:0]};
         2'b01: load_ext = funct3_q[2] ? {{(XLEN-16){1'b0}}, buf_q[15:0]}
                                       : {{(XLEN-16){buf_q[15]}}, buf_q[15:0]};
         default: load_ext = buf_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      funct3_d   = funct3_q;
      we_d       = we_q;
      buf_d      = buf_q;
      rdata_d    = rdata_q;
      stall_c    = 1'b0;
      done_c     = 1'b0;
      mem_we_c   = 1'b0;
      mem_addr_c = '0;
      mem_wd_c   = 8'h00;
      case (state_q)
         S_IDLE: begin
            stall_c = bus.req_valid;
            if (bus.req_valid) begin
               base_d   = bus.addr[ADDRESS_WIDTH-1:0];
               wdata_d  = bus.wdata;
               funct3_d = bus.funct3;
               we_d     = bus.req_we;
               idx_d    = 2'd0;
               state_d  = S_ACCESS;
            end
         end
         S_ACCESS: begin
            stall_c = 1'b1;
            // The address adder is ADDRESS_WIDTH wide, so a crossing of the
            // top of memory wraps to address 0.
            mem_addr_c = base_q + ADDRESS_WIDTH'(idx_q);
            if (we_q) begin
               mem_we_c = 1'b1;
               mem_wd_c = wdata_q[{idx_q, 3'b000} +: 8];
            end else begin
               buf_d[{idx_q, 3'b000} +: 8] = bus.mem_rd;
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == last_idx) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_c = 1'b1;
            if (!we_q) begin
               rdata_d = load_ext;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= 2'd0;
         base_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= 3'b000;
         we_q     <= 1'b0;
         buf_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         base_q   <= base_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         buf_q    <= buf_d;
         rdata_q  <= rdata_d;
      end
   end

   // Only the IDLE stall follows a live input. Gate it so that stall also
   // reads 0 during reset.
   assign bus.stall    = stall_c & ~rst;
   assign bus.done     = done_c;
   assign bus.mem_we   = mem_we_c;
   assign bus.mem_addr = mem_addr_c;
   assign bus.mem_wd   = mem_wd_c;
   // rdata_d already holds the freshly extended load during DONE, so the
   // writeback stage sees the result in the same cycle as done.
   assign bus.rdata    = rdata_d;

endmodule
